// File: rtl/multicyc_muldiv.sv
// Multicycle multiply/divide/accumulate unit producing a {HI,LO} result.
// One request in flight at a time; the result is held under a valid/ready handshake.
module multicyc_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_BITS   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [6:0]                req_op,
  input  logic [DATA_WIDTH-1:0]     req_reg0,
  input  logic [DATA_WIDTH-1:0]     req_reg1,
  input  logic [2*DATA_WIDTH-1:0]   req_hilo,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [2*DATA_WIDTH-1:0]   resp_hilo,
  output logic                      busy
);

  localparam int W         = DATA_WIDTH;
  localparam int DIV_STEPS = DATA_WIDTH / DIV_BITS;
  localparam int CNT_MAX   = (MUL_CYCLES > DIV_STEPS) ? MUL_CYCLES : DIV_STEPS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [6:0] OP_MULT  = 7'h18;
  localparam logic [6:0] OP_MULTU = 7'h19;
  localparam logic [6:0] OP_DIV   = 7'h1A;
  localparam logic [6:0] OP_DIVU  = 7'h1B;
  localparam logic [6:0] OP_MADD  = 7'h1C;
  localparam logic [6:0] OP_MADDU = 7'h1D;
  localparam logic [6:0] OP_MSUB  = 7'h1E;
  localparam logic [6:0] OP_MSUBU = 7'h1F;
  localparam logic [6:0] OP_MUL   = 7'h20;

  typedef enum logic [2:0] {
    IDLE, MUL, DIV_PRE, DIV_ITER, DIV_POST, DONE
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         op_q;
  logic [W-1:0]       reg0_q, reg1_q;
  logic [2*W-1:0]     hilo_q;
  logic [W-1:0]       div_rem, div_quo, div_den;
  logic               quo_neg, rem_neg;
  logic [2*W-1:0]     resp_hilo_q;

  function automatic logic is_mul_op(input logic [6:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU) || (op == OP_MUL);
  endfunction

  function automatic logic is_div_op(input logic [6:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Full-width product; the low 2W bits of a 2W x 2W multiply equal the signed product mod 2^2W.
  logic           mul_signed;
  logic [2*W-1:0] mul_a, mul_b, product, mul_result;

  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB) || (op_q == OP_MUL);
    mul_a      = mul_signed ? {{W{reg0_q[W-1]}}, reg0_q} : {{W{1'b0}}, reg0_q};
    mul_b      = mul_signed ? {{W{reg1_q[W-1]}}, reg1_q} : {{W{1'b0}}, reg1_q};
    product    = mul_a * mul_b;
    case (op_q)
      OP_MADD, OP_MADDU: mul_result = hilo_q + product;
      OP_MSUB, OP_MSUBU: mul_result = hilo_q - product;
      OP_MUL:            mul_result = {hilo_q[2*W-1:W], product[W-1:0]};
      default:           mul_result = product;
    endcase
  end

  // Restoring division: the dividend shifts out of div_quo while quotient bits shift in.
  logic [W-1:0] iter_rem, iter_quo;
  logic [W:0]   shifted;

  always_comb begin
    iter_rem = div_rem;
    iter_quo = div_quo;
    shifted  = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      shifted  = {iter_rem, iter_quo[W-1]};
      iter_quo = {iter_quo[W-2:0], 1'b0};
      if (shifted >= {1'b0, div_den}) begin
        shifted     = shifted - {1'b0, div_den};
        iter_quo[0] = 1'b1;
      end
      iter_rem = shifted[W-1:0];
    end
  end

  logic         div_signed;
  logic [W-1:0] abs0, abs1;
  logic [2*W-1:0] div_result;

  always_comb begin
    div_signed = (op_q == OP_DIV);
    abs0       = (div_signed && reg0_q[W-1]) ? -reg0_q : reg0_q;
    abs1       = (div_signed && reg1_q[W-1]) ? -reg1_q : reg1_q;
    if (reg1_q == '0)
      div_result = {reg0_q, {W{1'b1}}};
    else
      div_result = {(rem_neg ? -div_rem : div_rem), (quo_neg ? -div_quo : div_quo)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (is_mul_op(req_op))      state_next = MUL;
          else if (is_div_op(req_op)) state_next = DIV_PRE;
          else                        state_next = DONE;
        end
      end
      MUL:      if (cnt == '0) state_next = DONE;
      DIV_PRE:  state_next = DIV_ITER;
      DIV_ITER: if (cnt == '0) state_next = DIV_POST;
      DIV_POST: state_next = DONE;
      DONE:     if (resp_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath is frozen during flush so a dropped op never overwrites the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      op_q        <= '0;
      reg0_q      <= '0;
      reg1_q      <= '0;
      hilo_q      <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_den     <= '0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      resp_hilo_q <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            reg0_q <= req_reg0;
            reg1_q <= req_reg1;
            hilo_q <= req_hilo;
            cnt    <= CNT_W'(MUL_CYCLES - 1);
            if (!is_mul_op(req_op) && !is_div_op(req_op))
              resp_hilo_q <= req_hilo;
          end
        end
        MUL: begin
          if (cnt == '0) resp_hilo_q <= mul_result;
          else           cnt <= cnt - CNT_W'(1);
        end
        DIV_PRE: begin
          div_rem <= '0;
          div_quo <= abs0;
          div_den <= abs1;
          quo_neg <= div_signed && (reg0_q[W-1] ^ reg1_q[W-1]);
          rem_neg <= div_signed && reg0_q[W-1];
          cnt     <= CNT_W'(DIV_STEPS - 1);
        end
        DIV_ITER: begin
          div_rem <= iter_rem;
          div_quo <= iter_quo;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        DIV_POST: resp_hilo_q <= div_result;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE) && !flush;
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign resp_hilo  = resp_hilo_q;

endmodule

// File: tb/tb_multicyc_muldiv.sv
// Randomized self-checking bench for multicyc_muldiv against a plain-arithmetic model
// of results and handshake timing, plus hand-computed pinned cases.
module tb_multicyc_muldiv;

  localparam logic [6:0] OP_MULT  = 7'h18;
  localparam logic [6:0] OP_MULTU = 7'h19;
  localparam logic [6:0] OP_DIV   = 7'h1A;
  localparam logic [6:0] OP_DIVU  = 7'h1B;
  localparam logic [6:0] OP_MADD  = 7'h1C;
  localparam logic [6:0] OP_MADDU = 7'h1D;
  localparam logic [6:0] OP_MSUB  = 7'h1E;
  localparam logic [6:0] OP_MSUBU = 7'h1F;
  localparam logic [6:0] OP_MUL   = 7'h20;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, resp_ready;
  logic        req_ready, resp_valid, busy;
  logic [6:0]  req_op;
  logic [31:0] req_reg0, req_reg1;
  logic [63:0] req_hilo, resp_hilo;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicyc_muldiv #(.DATA_WIDTH(32), .MUL_CYCLES(3), .DIV_BITS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_reg0(req_reg0), .req_reg1(req_reg1), .req_hilo(req_hilo),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hilo(resp_hilo),
    .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mul(input logic [6:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
  endfunction

  function automatic int ref_lat(input logic [6:0] op);
    if (is_mul(op)) return 3;
    if (op == OP_DIV || op == OP_DIVU) return 34;
    return 0;
  endfunction

  function automatic logic [63:0] ref_hilo(input logic [6:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] h);
    logic [63:0] p;
    longint      ps;
    int          sa, sb, q, r;
    logic [31:0] qv, rv;
    if (op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL}) begin
      ps = longint'($signed(a)) * longint'($signed(b));
      p  = ps;
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    case (op)
      OP_MULT, OP_MULTU: return p;
      OP_MADD, OP_MADDU: return h + p;
      OP_MSUB, OP_MSUBU: return h - p;
      OP_MUL:            return {h[63:32], p[31:0]};
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a; sb = b;
        q = sa / sb; r = sa % sb;
        qv = q; rv = r;
        return {rv, qv};
      end
      OP_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return h;
    endcase
  endfunction

  // Reference model: tracks one outstanding op by cycles elapsed since accept.
  bit          m_on = 1'b0;
  bit          m_busy, m_known;
  int          m_count, m_lat;
  logic [63:0] m_result, m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_count = 0; m_lat = 0; m_last = '0; m_known = 1'b1; m_result = '0;
    end else if (flush) begin
      if (m_busy) m_known = (m_count >= m_lat);
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy   = 1'b1;
        m_count  = 0;
        m_result = ref_hilo(req_op, req_reg0, req_reg1, req_hilo);
        m_lat    = ref_lat(req_op);
        if (m_lat == 0) begin m_last = m_result; m_known = 1'b1; end
      end
    end else if (m_count >= m_lat && resp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_count++;
      if (m_count == m_lat) begin m_last = m_result; m_known = 1'b1; end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (m_on && !rst) begin
      checkOutput("busy", busy, m_busy);
      checkOutput("req_ready", req_ready, !m_busy && !flush);
      checkOutput("resp_valid", resp_valid, m_busy && (m_count >= m_lat));
      if (m_busy ? (m_count >= m_lat) : m_known)
        checkOutput("resp_hilo", resp_hilo, m_last);
    end
  end

  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] h, input int hold, input bit pin,
                               input logic [63:0] pin_hilo, input int pin_lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_reg0 = a; req_reg1 = b; req_hilo = h;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 7'($urandom);
    req_reg0  = $urandom;
    req_reg1  = $urandom;
    req_hilo  = {$urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      n_vec++; n_fail++;
      $display("[TB] FAIL resp_timeout: op 0x%0h got no resp_valid, expected one within 200 cycles", op);
    end else begin
      if (pin) begin
        checkOutput("pinned_latency", 64'(n), 64'(pin_lat));
        checkOutput("pinned_hilo", resp_hilo, pin_hilo);
      end
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic flushRun(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, input int at);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_reg0 = a; req_reg1 = b; req_hilo = h;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (at) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_resp_valid", resp_valid, 1'b0);
    checkOutput("flush_busy", busy, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [6:0] ops [11] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
                           OP_MSUB, OP_MSUBU, OP_MUL, 7'h00, 7'h05};

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_reg0 = '0; req_reg1 = '0; req_hilo = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 1'b1);
    checkOutput("reset_resp_valid", resp_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_resp_hilo", resp_hilo, 64'h0);
    rst  = 1'b0;
    m_on = 1'b1;

    $display("[TB] pinned cases");
    applyStimulus(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 0, 1, 64'h0000000000000001, 3);
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 0, 1, 64'hFFFFFFFE00000001, 3);
    applyStimulus(OP_MADD,  32'd3, 32'd4, 64'h0000000100000000, 0, 1, 64'h000000010000000C, 3);
    applyStimulus(OP_MSUB,  32'd3, 32'd4, 64'h0000000100000000, 0, 1, 64'h00000000FFFFFFF4, 3);
    applyStimulus(OP_MADDU, 32'd1, 32'd1, 64'hFFFFFFFFFFFFFFFF, 0, 1, 64'h0000000000000000, 3);
    applyStimulus(OP_MUL,   32'd5, 32'hFFFFFFFD, 64'h1234567800000000, 1, 1, 64'h12345678FFFFFFF1, 3);
    applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd2, 64'h0, 0, 1, 64'hFFFFFFFFFFFFFFFD, 34);
    applyStimulus(OP_DIVU,  32'd100, 32'd7, 64'h0, 0, 1, 64'h000000020000000E, 34);
    applyStimulus(OP_DIVU,  32'd10, 32'd0, 64'h0, 0, 1, 64'h0000000AFFFFFFFF, 34);
    applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h0, 0, 1, 64'h0000000080000000, 34);
    applyStimulus(7'h00,    32'd1, 32'd2, 64'hDEADBEEFCAFEF00D, 5, 1, 64'hDEADBEEFCAFEF00D, 0);
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 64'h0, 5, 1, 64'h000000000000002A, 3);

    $display("[TB] flush cases");
    flushRun(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'h0, 9);
    applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'd3, 64'h0, 0, 1, 64'hFFFFFFFFFFFFFFFA, 3);
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = OP_MULT; req_reg0 = 32'd2; req_reg1 = 32'd2;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_blocks_accept", busy, 1'b0);

    $display("[TB] reset mid-divide");
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIVU; req_reg0 = 32'd1000; req_reg1 = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", req_ready, 1'b1);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_resp_hilo", resp_hilo, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 10)];
      a  = pick_operand();
      b  = ($urandom_range(0, 5) == 0) ? 32'h0 : pick_operand();
      if ($urandom_range(0, 7) == 0)
        flushRun(op, a, b, {$urandom, $urandom}, $urandom_range(0, 40));
      else
        applyStimulus(op, a, b, {$urandom, $urandom}, $urandom_range(0, 3), 0, 64'h0, 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/multicyc_muldiv.md
Name: multicyc_muldiv

Overview:
Parametrised successor to the fixed 32-bit multicycle HI/LO unit used by the execute stage. It accepts one multiply/divide/accumulate request at a time and produces a 2*DATA_WIDTH hilo result. Multiply latency and divide radix are configurable, and the result is held under a valid/ready response handshake. It sits beside the EX pipe and is driven from multicyc_req_t fields; its result feeds the HI/LO register write.

Parameters:
DATA_WIDTH, 32, operand width; hilo is 2*DATA_WIDTH; must be even and >= 8.
MUL_CYCLES, 3, cycles from request accept to response for multiply-class ops; >= 1.
DIV_BITS, 1, quotient bits retired per cycle (1 or 2); DATA_WIDTH % DIV_BITS == 0.

Ports:
clk  in  1  clock; the only clock.
rst  in  1  asynchronous, active-high reset.
flush  in  1  abort the in-flight op; drop any held response.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request this cycle.
req_op  in  7  oper_t opcode.
req_reg0  in  DATA_WIDTH  rs operand (dividend or multiplicand).
req_reg1  in  DATA_WIDTH  rt operand (divisor or multiplier).
req_hilo  in  2*DATA_WIDTH  current {HI,LO}, used by MADD/MSUB/MUL.
resp_valid  out  1  result available.
resp_ready  in  1  consumer takes the result.
resp_hilo  out  2*DATA_WIDTH  result {HI,LO}.
busy  out  1  state is not IDLE.

Behaviour:
- One clock. Reset is asynchronous, active-high. On reset: state=IDLE, req_ready=1, resp_valid=0, resp_hilo=0, busy=0, and all counters and internal registers are 0.
- Accept condition: req_valid && req_ready at a rising edge (cycle T).
- req_ready = (state==IDLE) && !flush. There is no accept in the same cycle a response is consumed; the next accept is possible one cycle later.
- FSM states: IDLE, MUL, DIV_PRE, DIV_ITER, DIV_POST, DONE.
- IDLE -> MUL on accept of MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL.
- IDLE -> DIV_PRE on accept of DIV/DIVU.
- IDLE -> DONE on accept of any other op; resp_hilo = req_hilo (pass-through).
- MUL:
  - Counter runs MUL_CYCLES-1 -> 0; the state moves to DONE when the counter reaches 0.
  - resp_valid is asserted at cycle T+MUL_CYCLES.
- Multiply product P, 2*DATA_WIDTH bits:
  - Signed for MULT/MADD/MSUB/MUL; unsigned for MULTU/MADDU/MSUBU.
  - MULT/MULTU: result = P.
  - MADD/MADDU: result = req_hilo + P, modulo 2^(2*DATA_WIDTH).
  - MSUB/MSUBU: result = req_hilo - P, modulo 2^(2*DATA_WIDTH).
  - MUL: HI = req_hilo[2W-1:W] unchanged; LO = P[W-1:0].
- DIV_PRE: takes 1 cycle. Latches the absolute values of both operands (signed DIV) or the raw operands (DIVU). Records the quotient sign (sign0 XOR sign1) and the remainder sign (sign0).
- DIV_ITER:
  - Restoring division retiring DIV_BITS quotient bits per cycle.
  - Runs DATA_WIDTH/DIV_BITS cycles.
- DIV_POST: takes 1 cycle. Applies the sign fixups, then moves to DONE.
- Divide latency: resp_valid is asserted at T + DATA_WIDTH/DIV_BITS + 2. Default is T+34.
- Divide result: HI = remainder, LO = quotient.
  - The remainder takes the dividend's sign.
  - The quotient is truncated toward zero.
- Divide by zero, both signed and unsigned: HI = reg0 and LO = all ones. No exception is raised. Timing is unchanged.
- Signed overflow case (-2^(W-1) / -1): LO = -2^(W-1), HI = 0. Plain modulo arithmetic produces this result naturally.
- DONE:
  - resp_valid = 1, and resp_hilo is held stable until resp_ready.
  - DONE -> IDLE on resp_ready. resp_valid falls on the next cycle.
  - resp_hilo retains its last value after the handshake.
- flush:
  - In any state, the next state is IDLE and resp_valid is 0 on the next cycle.
  - No response is ever presented for a flushed op.
  - flush takes priority over both accept and resp_ready.
- busy = (state != IDLE).
- Operand registers are captured at accept; later changes on the req_* inputs have no effect.

Test Plan:
1. MULT 0xFFFFFFFF * 0xFFFFFFFF at T -> resp_valid at T+3, resp_hilo = 0x0000000000000001. The same operands with MULTU -> 0xFFFFFFFE00000001.
2. MADD with req_hilo = 0x0000000100000000, reg0 = 3, reg1 = 4 -> 0x000000010000000C. MSUB with the same inputs -> 0x00000000FFFFFFF4.
3. DIV -7 / 2 -> resp_hilo = {0xFFFFFFFF, 0xFFFFFFFD} at T+34. DIVU 100 / 7 -> {0x00000002, 0x0000000E}.
4. DIVU 10 / 0 -> {0x0000000A, 0xFFFFFFFF} at T+34. DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
5. Hold resp_ready = 0 for 5 cycles after resp_valid rises -> resp_hilo stays stable and req_ready stays 0. Raise resp_ready -> IDLE and req_ready = 1 on the next cycle.
6. Assert flush at cycle T+10 of a DIV -> resp_valid stays 0, busy = 0 on the next cycle, and a following MULT completes correctly. Asserting rst mid-DIV -> all outputs return to their reset values immediately.
